// File: rtl/control_pkg.sv
// Shared LEGv8 control definitions: opcode constants, ALUOp encoding and the staged control bundle.
package control_pkg;

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  // Short-opcode formats are matched on their top bits only
  localparam logic [9:0]  OP_ADDI = 10'b1001000100;
  localparam logic [7:0]  OP_CBZ  = 8'b10110100;
  localparam logic [5:0]  OP_B    = 6'b000101;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_PASS  = 2'b01,
    ALU_FUNCT = 2'b10
  } aluop_t;

  typedef struct packed {
    logic   alusrc;
    aluop_t aluop;
  } ex_ctrl_t;

  typedef struct packed {
    logic branch;
    logic uncond;
    logic memread;
    logic memwrite;
  } mem_ctrl_t;

  typedef struct packed {
    logic memtoreg;
    logic regwrite;
  } wb_ctrl_t;

  typedef struct packed {
    ex_ctrl_t  ex;
    mem_ctrl_t mem;
    wb_ctrl_t  wb;
  } ctrl_t;

  // Which source register fields the instruction actually reads
  typedef struct packed {
    logic rn;
    logic rm;
    logic rt;
  } rdmask_t;

  localparam ctrl_t BUBBLE = '0;

endpackage

// File: rtl/control_decode.sv
// Pure combinational opcode decode: control bundle, reg2loc, illegal flag and source read-mask.
module control_decode
  import control_pkg::*;
(
  input  logic [10:0] op,
  input  logic        valid,
  output ctrl_t       ctrl,
  output logic        reg2loc,
  output logic        illegal,
  output rdmask_t     rmask
);

  logic hit;

  always_comb begin
    ctrl    = BUBBLE;
    reg2loc = 1'b0;
    rmask   = '0;
    hit     = 1'b1;
    if (op == OP_ADD || op == OP_SUB || op == OP_AND || op == OP_ORR) begin
      ctrl.ex.aluop    = ALU_FUNCT;
      ctrl.wb.regwrite = 1'b1;
      rmask.rn         = 1'b1;
      rmask.rm         = 1'b1;
    end else if (op[10:1] == OP_ADDI) begin
      ctrl.ex.alusrc   = 1'b1;
      ctrl.ex.aluop    = ALU_FUNCT;
      ctrl.wb.regwrite = 1'b1;
      rmask.rn         = 1'b1;
    end else if (op == OP_LDUR) begin
      ctrl.ex.alusrc    = 1'b1;
      ctrl.ex.aluop     = ALU_ADD;
      ctrl.mem.memread  = 1'b1;
      ctrl.wb.memtoreg  = 1'b1;
      ctrl.wb.regwrite  = 1'b1;
      rmask.rn          = 1'b1;
    end else if (op == OP_STUR) begin
      reg2loc           = 1'b1;
      ctrl.ex.alusrc    = 1'b1;
      ctrl.ex.aluop     = ALU_ADD;
      ctrl.mem.memwrite = 1'b1;
      rmask.rn          = 1'b1;
      rmask.rt          = 1'b1;
    end else if (op[10:3] == OP_CBZ) begin
      reg2loc         = 1'b1;
      ctrl.ex.aluop   = ALU_PASS;
      ctrl.mem.branch = 1'b1;
      rmask.rt        = 1'b1;
    end else if (op[10:5] == OP_B) begin
      ctrl.mem.uncond = 1'b1;
    end else begin
      hit = 1'b0;
    end
  end

  assign illegal = valid & ~hit;

endmodule

// File: rtl/pipelined_control.sv
// LEGv8 5-stage control: ID decode, ID/EX, EX/MEM, MEM/WB control registers, flush/hold and stall counter.
// Optional LOAD_USE_STALL_EN enables internal load-use hazard detection.
module pipelined_control
  import control_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int XZR    = 31,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [31:0]      id_instr,
  input  logic             ext_stall,
  input  logic             mem_br_taken,
  output logic             id_reg2loc,
  output logic             id_hold,
  output logic             id_illegal,
  output logic             ex_alusrc,
  output logic [1:0]       ex_aluop,
  output logic             mem_branch,
  output logic             mem_uncond,
  output logic             mem_memread,
  output logic             mem_memwrite,
  output logic             wb_memtoreg,
  output logic             wb_regwrite,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [REG_AW-1:0] XZR_A = REG_AW'(XZR);

  ctrl_t              id_ctrl, ex_c, mem_c, wb_c;
  rdmask_t            id_rmask;
  logic [REG_AW-1:0]  id_rn, id_rm, id_rt;
  logic [REG_AW-1:0]  ex_rd, mem_rd, wb_rd;
  logic [3:1]         vld_pipe;  // [1]=EX, [2]=MEM, [3]=WB
  logic               load_use;

  assign id_rn = id_instr[5 +: REG_AW];
  assign id_rm = id_instr[16 +: REG_AW];
  assign id_rt = id_instr[0 +: REG_AW];

  control_decode u_dec (
    .op      (id_instr[31:21]),
    .valid   (id_valid),
    .ctrl    (id_ctrl),
    .reg2loc (id_reg2loc),
    .illegal (id_illegal),
    .rmask   (id_rmask)
  );

`ifdef LOAD_USE_STALL_EN
  assign load_use = vld_pipe[1] & ex_c.mem.memread & (ex_rd != XZR_A) & id_valid & ~id_illegal &
                    ((id_rmask.rn & (id_rn == ex_rd)) |
                     (id_rmask.rm & (id_rm == ex_rd)) |
                     (id_rmask.rt & (id_rt == ex_rd)));
`else
  assign load_use = 1'b0;
  logic unused_lu;
  assign unused_lu = ^{id_rmask, id_rn, id_rm, id_rt, XZR_A};
`endif

  // A taken branch redirects fetch, so it overrides any stall request
  assign id_hold = ~mem_br_taken & (ext_stall | load_use);

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_pipe  <= '0;
      ex_c      <= BUBBLE;
      mem_c     <= BUBBLE;
      wb_c      <= BUBBLE;
      ex_rd     <= '0;
      mem_rd    <= '0;
      wb_rd     <= '0;
      stall_cnt <= '0;
    end else begin
      vld_pipe[3] <= vld_pipe[2];
      wb_c        <= mem_c;
      wb_rd       <= mem_rd;
      if (mem_br_taken) begin
        vld_pipe[2:1] <= '0;
        mem_c         <= BUBBLE;
        ex_c          <= BUBBLE;
      end else begin
        vld_pipe[2] <= vld_pipe[1];
        mem_c       <= ex_c;
        mem_rd      <= ex_rd;
        if (id_hold) begin
          vld_pipe[1] <= 1'b0;
          ex_c        <= BUBBLE;
        end else begin
          vld_pipe[1] <= id_valid & ~id_illegal;
          ex_c        <= id_ctrl;
          ex_rd       <= id_rt;
        end
      end
      if (id_hold && stall_cnt != {CNT_W{1'b1}})
        stall_cnt <= stall_cnt + 1'b1;
    end
  end

  assign ex_alusrc    = vld_pipe[1] & ex_c.ex.alusrc;
  assign ex_aluop     = {2{vld_pipe[1]}} & ex_c.ex.aluop;
  assign mem_branch   = vld_pipe[2] & mem_c.mem.branch;
  assign mem_uncond   = vld_pipe[2] & mem_c.mem.uncond;
  assign mem_memread  = vld_pipe[2] & mem_c.mem.memread;
  assign mem_memwrite = vld_pipe[2] & mem_c.mem.memwrite;
  assign wb_memtoreg  = vld_pipe[3] & wb_c.wb.memtoreg;
  assign wb_regwrite  = vld_pipe[3] & wb_c.wb.regwrite;

  // Destination address is carried for the datapath side; control itself does not consume it in WB
  logic unused_ok;
  assign unused_ok = ^{id_instr[15:10], wb_rd};

endmodule

// File: tb/tb_pipelined_control.sv
// Self-checking bench for pipelined_control: decode table through a stage scoreboard plus hazard sequences.
module tb_pipelined_control;

  logic        clk = 1'b0;
  logic        reset, id_valid, ext_stall, mem_br_taken;
  logic [31:0] id_instr;

  logic        id_reg2loc, id_hold, id_illegal, ex_alusrc;
  logic [1:0]  ex_aluop;
  logic        mem_branch, mem_uncond, mem_memread, mem_memwrite, wb_memtoreg, wb_regwrite;
  logic [15:0] stall_cnt;

  logic        d2_reg2loc, d2_hold, d2_illegal, d2_alusrc;
  logic [1:0]  d2_aluop;
  logic        d2_branch, d2_uncond, d2_memread, d2_memwrite, d2_memtoreg, d2_regwrite;
  logic [1:0]  d2_stall_cnt;

  pipelined_control dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_instr(id_instr),
    .ext_stall(ext_stall), .mem_br_taken(mem_br_taken),
    .id_reg2loc(id_reg2loc), .id_hold(id_hold), .id_illegal(id_illegal),
    .ex_alusrc(ex_alusrc), .ex_aluop(ex_aluop),
    .mem_branch(mem_branch), .mem_uncond(mem_uncond), .mem_memread(mem_memread),
    .mem_memwrite(mem_memwrite), .wb_memtoreg(wb_memtoreg), .wb_regwrite(wb_regwrite),
    .stall_cnt(stall_cnt)
  );

  pipelined_control #(.CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_instr(id_instr),
    .ext_stall(ext_stall), .mem_br_taken(mem_br_taken),
    .id_reg2loc(d2_reg2loc), .id_hold(d2_hold), .id_illegal(d2_illegal),
    .ex_alusrc(d2_alusrc), .ex_aluop(d2_aluop),
    .mem_branch(d2_branch), .mem_uncond(d2_uncond), .mem_memread(d2_memread),
    .mem_memwrite(d2_memwrite), .wb_memtoreg(d2_memtoreg), .wb_regwrite(d2_regwrite),
    .stall_cnt(d2_stall_cnt)
  );

  always #5 clk = ~clk;

`ifdef LOAD_USE_STALL_EN
  localparam logic LU = 1'b1;
`else
  localparam logic LU = 1'b0;
`endif

  localparam logic [10:0] ADD = 11'b10001011000, SUB = 11'b11001011000, AND = 11'b10001010000,
                          ORR = 11'b10101010000, ADDI = 11'b10010001000, LDUR = 11'b11111000010,
                          STUR = 11'b11111000000, CBZ = 11'b10110100000, BR = 11'b00010100000,
                          BAD = 11'b11111111111;

  wire [2:0] ex_o  = {ex_alusrc, ex_aluop};
  wire [3:0] mem_o = {mem_branch, mem_uncond, mem_memread, mem_memwrite};
  wire [1:0] wb_o  = {wb_memtoreg, wb_regwrite};

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [2:0] ex;
    logic [3:0] mem;
    logic [1:0] wb;
  } exp_t;

  typedef struct {
    logic [31:0] instr;
    logic        valid;
    exp_t        e;
    logic        r2l;
    logic        ill;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [10:0] op, input logic [4:0] rm, input logic [4:0] rn,
                                     input logic [4:0] rd);
    return {op, rm, 6'b0, rn, rd};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] ins);
    id_valid = v;
    id_instr = ins;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    logic [1:0] sat_exp[6];
    sat_exp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3};

    //            instr                  valid  ex      mem      wb     r2l  ill
    tbl[0]  = '{mk(ADD, 5'd3, 5'd2, 5'd1),  1'b1, '{3'b010, 4'b0000, 2'b01}, 1'b0, 1'b0};
    tbl[1]  = '{mk(SUB, 5'd3, 5'd2, 5'd4),  1'b1, '{3'b010, 4'b0000, 2'b01}, 1'b0, 1'b0};
    tbl[2]  = '{mk(AND, 5'd3, 5'd2, 5'd4),  1'b1, '{3'b010, 4'b0000, 2'b01}, 1'b0, 1'b0};
    tbl[3]  = '{mk(ORR, 5'd3, 5'd2, 5'd4),  1'b1, '{3'b010, 4'b0000, 2'b01}, 1'b0, 1'b0};
    tbl[4]  = '{mk(ADDI, 5'd0, 5'd2, 5'd7), 1'b1, '{3'b110, 4'b0000, 2'b01}, 1'b0, 1'b0};
    tbl[5]  = '{mk(LDUR, 5'd0, 5'd9, 5'd5), 1'b1, '{3'b100, 4'b0010, 2'b11}, 1'b0, 1'b0};
    tbl[6]  = '{mk(STUR, 5'd0, 5'd10, 5'd8),1'b1, '{3'b100, 4'b0001, 2'b00}, 1'b1, 1'b0};
    tbl[7]  = '{mk(CBZ, 5'd0, 5'd0, 5'd11), 1'b1, '{3'b001, 4'b1000, 2'b00}, 1'b1, 1'b0};
    tbl[8]  = '{mk(BR, 5'd0, 5'd0, 5'd4),   1'b1, '{3'b000, 4'b0100, 2'b00}, 1'b0, 1'b0};
    tbl[9]  = '{mk(BAD, 5'd3, 5'd2, 5'd1),  1'b1, '{3'b000, 4'b0000, 2'b00}, 1'b0, 1'b1};
    tbl[10] = '{mk(ADD, 5'd3, 5'd2, 5'd1),  1'b1, '{3'b010, 4'b0000, 2'b01}, 1'b0, 1'b0};
    tbl[11] = '{mk(ADD, 5'd3, 5'd2, 5'd1),  1'b0, '{3'b000, 4'b0000, 2'b00}, 1'b0, 1'b0};
    tbl[12] = '{mk(STUR, 5'd0, 5'd10, 5'd8),1'b0, '{3'b000, 4'b0000, 2'b00}, 1'b1, 1'b0};

    // Reset held two cycles while ADD streams in
    reset = 1'b1; ext_stall = 1'b0; mem_br_taken = 1'b0;
    drive(1'b1, mk(ADD, 5'd3, 5'd2, 5'd1));
    tick(); tick();
    chk("reset_pipe", {ex_o, mem_o, wb_o}, 0);
    chk("reset_cnt", stall_cnt, 0);
    chk("reset_cnt2", d2_stall_cnt, 0);
    reset = 1'b0;

    // Decode table through the stage scoreboard
    sb.push_back('0);
    sb.push_back('0);
    for (int i = 0; i < 13; i++) begin
      drive(tbl[i].valid, tbl[i].instr);
      #1;
      chk($sformatf("reg2loc[%0d]", i), id_reg2loc, tbl[i].r2l);
      chk($sformatf("illegal[%0d]", i), id_illegal, tbl[i].ill);
      chk($sformatf("hold[%0d]", i), id_hold, 0);
      tick();
      sb.push_back(tbl[i].e);
      chk($sformatf("ex[%0d]", i), ex_o, sb[$].ex);
      chk($sformatf("mem[%0d]", i), mem_o, sb[$-1].mem);
      chk($sformatf("wb[%0d]", i), wb_o, sb[$-2].wb);
      if (sb.size() > 3) void'(sb.pop_front());
    end

    // Reset mid-stream drops everything in flight in one cycle
    drive(1'b1, mk(ADD, 5'd3, 5'd2, 5'd1)); tick();
    drive(1'b1, mk(LDUR, 5'd0, 5'd9, 5'd5)); tick();
    pulse_reset();
    chk("midreset_pipe", {ex_o, mem_o, wb_o}, 0);

    // Load-use: LDUR X5 then ADD X6,X5,X7
    drive(1'b1, mk(LDUR, 5'd0, 5'd9, 5'd5)); tick();
    drive(1'b1, mk(ADD, 5'd7, 5'd5, 5'd6)); #1;
    chk("lu_hold", id_hold, LU);
    tick();
    chk("lu_memread", mem_memread, 1);
`ifdef LOAD_USE_STALL_EN
    chk("lu_ex_bubble", ex_o, 3'b000);
    chk("lu_cnt", stall_cnt, 1);
    chk("lu_hold_once", id_hold, 0);
    tick();
    chk("lu_ex_after", ex_o, 3'b010);
`else
    chk("nolu_ex", ex_o, 3'b010);
    chk("nolu_cnt", stall_cnt, 0);
`endif
    // Same with destination XZR: never a hazard
    drive(1'b1, mk(LDUR, 5'd0, 5'd9, 5'd31)); tick();
    drive(1'b1, mk(ADD, 5'd7, 5'd31, 5'd6)); #1;
    chk("xzr_hold", id_hold, 0);
    tick();
    chk("xzr_ex", ex_o, 3'b010);
    chk("xzr_cnt", stall_cnt, {15'd0, LU});

    // CBZ reads rt; B reads nothing even when its immediate bits alias the load target
    drive(1'b1, mk(LDUR, 5'd0, 5'd9, 5'd12)); tick();
    drive(1'b1, mk(CBZ, 5'd0, 5'd0, 5'd12)); #1;
    chk("lu_cbz_hold", id_hold, LU);
    drive(1'b0, 32'd0); tick(); tick();
    drive(1'b1, mk(LDUR, 5'd0, 5'd9, 5'd12)); tick();
    drive(1'b1, mk(BR, 5'd12, 5'd12, 5'd12)); #1;
    chk("lu_b_hold", id_hold, 0);
    drive(1'b0, 32'd0); tick(); tick();

    // Branch flush with a simultaneous external stall
    pulse_reset();
    drive(1'b1, mk(ADD, 5'd3, 5'd2, 5'd1)); tick();
    drive(1'b1, mk(CBZ, 5'd0, 5'd0, 5'd3)); tick();
    drive(1'b1, mk(ADDI, 5'd0, 5'd2, 5'd7)); tick();
    chk("br_pre_mem", mem_o, 4'b1000);
    chk("br_pre_wb", wb_o, 2'b01);
    drive(1'b1, mk(SUB, 5'd3, 5'd2, 5'd4));
    ext_stall = 1'b1; mem_br_taken = 1'b1; #1;
    chk("br_hold", id_hold, 0);
    tick();
    mem_br_taken = 1'b0;
    chk("br_ex", ex_o, 3'b000);
    chk("br_mem", mem_o, 4'b0000);
    chk("br_wb_adv", wb_o, 2'b00);
    chk("br_cnt", stall_cnt, 0);
    #1;
    chk("stall_hold", id_hold, 1);
    tick();
    ext_stall = 1'b0;
    chk("stall_ex", ex_o, 3'b000);
    chk("stall_cnt", stall_cnt, 1);

    // Saturating counter: CNT_W=2 instance alongside the 16-bit one
    pulse_reset();
    drive(1'b1, mk(ADD, 5'd3, 5'd2, 5'd1));
    ext_stall = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("sat2[%0d]", i), d2_stall_cnt, sat_exp[i]);
      chk($sformatf("cnt16[%0d]", i), stall_cnt, i + 1);
      chk($sformatf("sat_ex[%0d]", i), ex_o, 3'b000);
    end
    ext_stall = 1'b0;
    tick();
    chk("sat_release_ex", ex_o, 3'b010);
    chk("sat_hold_val", d2_stall_cnt, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
